// File: rtl/cpu_mem_pkg.sv
// Shared constants and state encoding for the CPU <-> 16-bit data memory path.
//   MEM_W       : data memory port width in bits
//   HALF_BYTES  : bytes per memory beat (address step between beats)
//   mem_state_e : beat sequencer states shared by load/store controllers
package cpu_mem_pkg;

    localparam int unsigned MEM_W      = 16;
    localparam int unsigned HALF_BYTES = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFirst = 2'd1,
        StLast  = 2'd2
    } mem_state_e;

endpackage

// File: rtl/store_align_check.sv
// Combinational alignment check for halfword/word memory requests.
// Ports:
//   addr       : low two bits of the byte address
//   is_half    : 1 = halfword access, 0 = word access
//   misaligned : 1 when the address is not naturally aligned for the access size
module store_align_check (
    input  logic [1:0] addr,
    input  logic       is_half,
    output logic       misaligned
);

    assign misaligned = is_half ? addr[0] : (addr != 2'b00);

endmodule

// File: rtl/store_half_narrower.sv
// Store-path narrower: splits a 32-bit store into 16-bit memory beats.
// SW emits two beats (addr, addr+2), SH emits one truncated beat.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready              : request handshake
//   in_data, in_addr, in_is_half   : store request fields
//   out_valid/out_ready            : memory beat handshake
//   out_data, out_addr, out_last   : beat fields (out_last marks final beat)
//   trunc_err                      : 1-cycle pulse, SH accepted with non-zero upper half
//   align_err                      : 1-cycle pulse, misaligned request dropped
module store_half_narrower
    import cpu_mem_pkg::*;
#(
    parameter bit          LOW_FIRST = 1'b1,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*MEM_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_is_half,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MEM_W-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              trunc_err,
    output logic              align_err
);

    mem_state_e        state_q, state_d;
    logic [MEM_W-1:0]  data_q, data_d;
    logic [MEM_W-1:0]  second_q, second_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_q, last_d;
    logic              trunc_q, trunc_d;
    logic              align_q, align_d;

    logic             misaligned;
    logic             accept;
    logic             take;
    logic [MEM_W-1:0] lo_half;
    logic [MEM_W-1:0] hi_half;

    store_align_check u_align (
        .addr       (in_addr[1:0]),
        .is_half    (in_is_half),
        .misaligned (misaligned)
    );

    assign lo_half = in_data[MEM_W-1:0];
    assign hi_half = in_data[2*MEM_W-1:MEM_W];

    // In LAST a new request may be taken in the cycle the final beat completes.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle:  in_ready = 1'b1;
                StLast:  in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        second_d = second_q;
        addr_d   = addr_q;
        last_d   = last_q;
        trunc_d  = 1'b0;
        align_d  = 1'b0;
        take     = 1'b0;

        unique case (state_q)
            StIdle: take = 1'b1;
            StFirst: begin
                if (out_ready) begin
                    data_d  = second_q;
                    addr_d  = addr_q + ADDR_W'(HALF_BYTES);
                    last_d  = 1'b1;
                    state_d = StLast;
                end
            end
            StLast: begin
                if (out_ready) begin
                    take    = 1'b1;
                    last_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A request taken here overrides the idle fallback chosen above.
        if (take && accept) begin
            if (misaligned) begin
                align_d = 1'b1;
                last_d  = 1'b0;
                state_d = StIdle;
            end else if (in_is_half) begin
                data_d  = lo_half;
                addr_d  = in_addr;
                last_d  = 1'b1;
                trunc_d = |hi_half;
                state_d = StLast;
            end else begin
                data_d   = LOW_FIRST ? lo_half : hi_half;
                second_d = LOW_FIRST ? hi_half : lo_half;
                addr_d   = in_addr;
                last_d   = 1'b0;
                state_d  = StFirst;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            data_q   <= '0;
            second_q <= '0;
            addr_q   <= '0;
            last_q   <= 1'b0;
            trunc_q  <= 1'b0;
            align_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            second_q <= second_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            trunc_q  <= trunc_d;
            align_q  <= align_d;
        end
    end

    assign out_valid = (state_q != StIdle);
    assign out_data  = data_q;
    assign out_addr  = addr_q;
    assign out_last  = last_q;
    assign trunc_err = trunc_q;
    assign align_err = align_q;

endmodule
